// File: rtl/fp16_pkg.sv
// Shared FP16 widths, special encodings, FSM state type and unpacked-operand type
// for the stream accumulator.
package fp16_pkg;

  localparam int unsigned FLOAT_WIDTH = 16;
  localparam int unsigned EXP_WIDTH   = 5;
  localparam int unsigned MANT_WIDTH  = 10;
  localparam int unsigned COUNT_WIDTH = 8;
  // hidden bit + stored mantissa + guard/round/sticky
  localparam int unsigned EXT_WIDTH   = MANT_WIDTH + 4;

  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;

  localparam logic [FLOAT_WIDTH-1:0] QNAN    = 16'h7E00;
  localparam logic [FLOAT_WIDTH-1:0] POS_INF = 16'h7C00;
  localparam logic [FLOAT_WIDTH-1:0] NEG_INF = 16'hFC00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_OUT
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_WIDTH-1:0] exp;
    logic [EXT_WIDTH-1:0] sig;
  } ufloat_t;

  // Exponent-zero encodings unpack to a zero significand (flush-to-zero).
  function automatic ufloat_t unpack_fp16(input logic [FLOAT_WIDTH-1:0] x);
    ufloat_t u;
    u.sign = x[FLOAT_WIDTH-1];
    u.exp  = x[FLOAT_WIDTH-2:MANT_WIDTH];
    u.sig  = (u.exp == '0) ? '0 : {1'b1, x[MANT_WIDTH-1:0], 3'b000};
    return u;
  endfunction

endpackage

// File: rtl/fp16_stream_accumulator_if.sv
// Valid/ready element input and frame-sum output bundle of the FP16 stream accumulator.
// out_ovf exists only when FP_ACC_OVF_FLAG_EN is defined.
interface fp16_stream_accumulator_if;
  import fp16_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [FLOAT_WIDTH-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [FLOAT_WIDTH-1:0] out_data;
  logic [COUNT_WIDTH-1:0] out_count;
`ifdef FP_ACC_OVF_FLAG_EN
  logic                   out_ovf;

  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_count, out_ovf);
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_count, out_ovf);
`else
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_count);
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_count);
`endif

endinterface

// File: rtl/fp16_rne_round.sv
// Packs a normalized extended significand into FP16 with round-to-nearest-even
// and overflow to signed infinity.
module fp16_rne_round
  import fp16_pkg::*;
(
  input  logic                   sign,
  input  logic [EXP_WIDTH:0]     exponent,
  input  logic [EXT_WIDTH-1:0]   sig,
  output logic [FLOAT_WIDTH-1:0] result_c
);

  logic                  round_up;
  logic [MANT_WIDTH+1:0] mant;
  logic [EXP_WIDTH:0]    exp_r;

  always_comb begin
    round_up = sig[2] & (sig[3] | sig[1] | sig[0]);
    mant     = {1'b0, sig[EXT_WIDTH-1:3]} + (MANT_WIDTH+2)'(round_up);
    exp_r    = exponent + (EXP_WIDTH+1)'(mant[MANT_WIDTH+1]);
    if (sig == '0 || exponent == '0) begin
      result_c = {sign, (FLOAT_WIDTH-1)'(0)};
    end else if (exp_r >= (EXP_WIDTH+1)'(EXP_MAX)) begin
      result_c = sign ? NEG_INF : POS_INF;
    end else begin
      result_c = {sign, exp_r[EXP_WIDTH-1:0],
                  mant[MANT_WIDTH+1] ? mant[MANT_WIDTH:1] : mant[MANT_WIDTH-1:0]};
    end
  end

endmodule

// File: rtl/fp16_stream_accumulator.sv
// Sums a framed FP16 stream through a multi-cycle align/add/normalize/round datapath.
// Define FP_ACC_OVF_FLAG_EN to add the sticky per-frame out_ovf flag.
module fp16_stream_accumulator
  import fp16_pkg::*;
(
  input logic clk,
  input logic rst,
  fp16_stream_accumulator_if.slave bus
);

  state_t                 state;
  logic [FLOAT_WIDTH-1:0] acc;
  logic [FLOAT_WIDTH-1:0] op;
  logic [COUNT_WIDTH-1:0] count;
  logic                   last_q;
  logic                   nan_seen;
  logic                   pinf_seen;
  logic                   ninf_seen;
  ufloat_t                big_q;
  logic                   small_sign_q;
  logic [EXT_WIDTH-1:0]   small_sig_q;
  logic                   res_sign;
  logic [EXP_WIDTH:0]     res_exp;
  logic [EXT_WIDTH:0]     res_sig;
`ifdef FP_ACC_OVF_FLAG_EN
  logic                   ovf_seen;
`endif

  ufloat_t                ua, ub, big_c, small_c;
  logic [EXP_WIDTH-1:0]   diff_c;
  logic [EXT_WIDTH-1:0]   shifted_c, lost_c;
  logic [EXT_WIDTH:0]     sum_c;
  logic                   sum_sign_c;
  logic [FLOAT_WIDTH-1:0] rounded_c, frame_c;
  logic                   special_c, ovf_now_c;
  logic                   in_exp_max_c, in_nan_c, in_inf_c;

  // Alignment: smaller-exponent operand shifted right, lost bits folded into sticky.
  always_comb begin
    ua      = unpack_fp16(acc);
    ub      = unpack_fp16(op);
    big_c   = ua;
    small_c = ub;
    if (ua.exp < ub.exp) begin
      big_c   = ub;
      small_c = ua;
    end
    diff_c    = big_c.exp - small_c.exp;
    shifted_c = '0;
    lost_c    = '0;
    if (diff_c > EXP_WIDTH'(EXT_WIDTH - 1)) begin
      shifted_c = EXT_WIDTH'(|small_c.sig);
    end else begin
      shifted_c    = small_c.sig >> diff_c;
      lost_c       = small_c.sig << (EXP_WIDTH'(EXT_WIDTH) - diff_c);
      shifted_c[0] = shifted_c[0] | (|lost_c);
    end
  end

  // Magnitude add/subtract; the larger magnitude sets the sign.
  always_comb begin
    sum_c      = {1'b0, big_q.sig} + {1'b0, small_sig_q};
    sum_sign_c = big_q.sign;
    if (big_q.sign != small_sign_q) begin
      if (big_q.sig >= small_sig_q) begin
        sum_c = {1'b0, big_q.sig - small_sig_q};
      end else begin
        sum_c      = {1'b0, small_sig_q - big_q.sig};
        sum_sign_c = small_sign_q;
      end
    end
  end

  fp16_rne_round u_round (
    .sign     (res_sign),
    .exponent (res_exp),
    .sig      (res_sig[EXT_WIDTH-1:0]),
    .result_c (rounded_c)
  );

  always_comb begin
    in_exp_max_c = bus.in_data[FLOAT_WIDTH-2:MANT_WIDTH] == EXP_WIDTH'(EXP_MAX);
    in_nan_c     = in_exp_max_c & (|bus.in_data[MANT_WIDTH-1:0]);
    in_inf_c     = in_exp_max_c & ~(|bus.in_data[MANT_WIDTH-1:0]);
    special_c    = nan_seen | pinf_seen | ninf_seen;
    ovf_now_c    = ~special_c & (rounded_c[FLOAT_WIDTH-2:MANT_WIDTH] == EXP_WIDTH'(EXP_MAX));
    frame_c      = rounded_c;
    if (nan_seen || (pinf_seen && ninf_seen)) begin
      frame_c = QNAN;
    end else if (pinf_seen) begin
      frame_c = POS_INF;
    end else if (ninf_seen) begin
      frame_c = NEG_INF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      acc           <= '0;
      op            <= '0;
      count         <= '0;
      last_q        <= 1'b0;
      nan_seen      <= 1'b0;
      pinf_seen     <= 1'b0;
      ninf_seen     <= 1'b0;
      big_q         <= '0;
      small_sign_q  <= 1'b0;
      small_sig_q   <= '0;
      res_sign      <= 1'b0;
      res_exp       <= '0;
      res_sig       <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_count <= '0;
`ifdef FP_ACC_OVF_FLAG_EN
      ovf_seen      <= 1'b0;
      bus.out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            op           <= bus.in_data;
            last_q       <= bus.in_last;
            count        <= (count == '1) ? count : count + COUNT_WIDTH'(1);
            nan_seen     <= nan_seen | in_nan_c;
            pinf_seen    <= pinf_seen | (in_inf_c & ~bus.in_data[FLOAT_WIDTH-1]);
            ninf_seen    <= ninf_seen | (in_inf_c & bus.in_data[FLOAT_WIDTH-1]);
            bus.in_ready <= 1'b0;
            state        <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          big_q        <= big_c;
          small_sign_q <= small_c.sign;
          small_sig_q  <= shifted_c;
          state        <= S_ADD;
        end
        S_ADD: begin
          res_sign <= sum_sign_c;
          res_exp  <= {1'b0, big_q.exp};
          res_sig  <= sum_c;
          state    <= S_NORM;
        end
        // One left shift per cycle until the hidden bit lands; leaves early on carry/zero/FTZ.
        S_NORM: begin
          if (res_sig[EXT_WIDTH]) begin
            res_sig <= {1'b0, res_sig[EXT_WIDTH:2], res_sig[1] | res_sig[0]};
            res_exp <= res_exp + (EXP_WIDTH+1)'(1);
            state   <= S_ROUND;
          end else if (res_sig == '0) begin
            res_sign <= 1'b0;
            state    <= S_ROUND;
          end else if (res_sig[EXT_WIDTH-1]) begin
            state <= S_ROUND;
          end else if (res_exp <= (EXP_WIDTH+1)'(1)) begin
            res_sig <= '0;
            res_exp <= '0;
            state   <= S_ROUND;
          end else begin
            res_sig <= res_sig << 1;
            res_exp <= res_exp - (EXP_WIDTH+1)'(1);
            if (res_sig[EXT_WIDTH-2]) begin
              state <= S_ROUND;
            end
          end
        end
        S_ROUND: begin
          acc <= frame_c;
          if (ovf_now_c) begin
            pinf_seen <= pinf_seen | ~rounded_c[FLOAT_WIDTH-1];
            ninf_seen <= ninf_seen | rounded_c[FLOAT_WIDTH-1];
          end
`ifdef FP_ACC_OVF_FLAG_EN
          if (ovf_now_c) begin
            ovf_seen <= 1'b1;
          end
`endif
          if (last_q) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= frame_c;
            bus.out_count <= count;
`ifdef FP_ACC_OVF_FLAG_EN
            bus.out_ovf   <= ovf_seen | ovf_now_c;
`endif
            state         <= S_OUT;
          end else begin
            bus.in_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            acc           <= '0;
            count         <= '0;
            nan_seen      <= 1'b0;
            pinf_seen     <= 1'b0;
            ninf_seen     <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
`ifdef FP_ACC_OVF_FLAG_EN
            ovf_seen      <= 1'b0;
            bus.out_ovf   <= 1'b0;
`endif
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_stream_accumulator.sv
// Directed bench for fp16_stream_accumulator: hand-computed frame sums, timing,
// backpressure, specials, count saturation and mid-frame reset.
module tb_fp16_stream_accumulator;
  import fp16_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] one_val;

  fp16_stream_accumulator_if bus ();

  fp16_stream_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic send_elem(input logic [15:0] data, input logic last);
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 200 cycles", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic recv_result(output logic [15:0] data, output logic [7:0] cnt, output logic ovf);
    int n = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL recv_timeout: out_valid=%b, required 1 within 200 cycles", bus.out_valid);
    end
    data = bus.out_data;
    cnt  = bus.out_count;
`ifdef FP_ACC_OVF_FLAG_EN
    ovf  = bus.out_ovf;
`else
    ovf  = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h out_count=%0d, required 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_count);
    end
`ifdef FP_ACC_OVF_FLAG_EN
    checks++;
    if (bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: out_ovf=%b, required 0", bus.out_ovf);
    end
`endif
    // in_last without in_valid must not start anything
    bus.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL last_without_valid: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
      end
    end
    bus.in_last = 1'b0;
  endtask

  task automatic test_special();
    logic [15:0] a [8] = '{16'h7C00, 16'h7C00, 16'h3C00, 16'hFC00, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] b [8] = '{16'h3C00, 16'hFC00, 16'h7E01, 16'hC000, 16'h8000, 16'h0001, 16'hBC00, 16'h8001};
    logic        s [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] e [8] = '{16'h7C00, 16'h7E00, 16'h7E00, 16'hFC00, 16'h0000, 16'h0000, 16'hBC00, 16'h0000};
    logic [15:0] d;
    logic [7:0]  c;
    logic        o;
    logic [7:0]  ec;
    for (int i = 0; i < 8; i++) begin
      if (!s[i]) send_elem(a[i], 1'b0);
      send_elem(b[i], 1'b1);
      recv_result(d, c, o);
      ec = s[i] ? 8'd1 : 8'd2;
      checks++;
      if (d !== e[i] || c !== ec) begin
        errors++;
        $display("FAIL special[%0d]: out_data=%h out_count=%0d, required %h %0d", i, d, c, e[i], ec);
      end
`ifdef FP_ACC_OVF_FLAG_EN
      checks++;
      if (o !== 1'b0) begin
        errors++;
        $display("FAIL special_ovf[%0d]: out_ovf=%b, required 0", i, o);
      end
`endif
    end
  endtask

  task automatic test_arith();
    logic [15:0] a [9] = '{16'h3C00, 16'h34CD, 16'h34CD, 16'h3C00, 16'h4000, 16'h3C00, 16'h3C01, 16'h3C00, 16'hC000};
    logic [15:0] b [9] = '{16'h3C00, 16'h3266, 16'h34CD, 16'hBC00, 16'hBC00, 16'h1000, 16'h1000, 16'h0400, 16'h3C00};
    logic [15:0] e [9] = '{16'h4000, 16'h3800, 16'h38CD, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C02, 16'h3C00, 16'hBC00};
    logic [15:0] d;
    logic [7:0]  c;
    logic        o;
    for (int i = 0; i < 9; i++) begin
      send_elem(a[i], 1'b0);
      send_elem(b[i], 1'b1);
      recv_result(d, c, o);
      checks++;
      if (d !== e[i] || c !== 8'd2) begin
        errors++;
        $display("FAIL arith[%0d]: out_data=%h out_count=%0d, required %h 2", i, d, c, e[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    logic [7:0]  c;
    logic        o;
    send_elem(16'h7BFF, 1'b0);
    send_elem(16'h7BFF, 1'b1);
    recv_result(d, c, o);
    checks++;
    if (d !== 16'h7C00 || c !== 8'd2) begin
      errors++;
      $display("FAIL ovf_pos: out_data=%h out_count=%0d, required 7c00 2", d, c);
    end
`ifdef FP_ACC_OVF_FLAG_EN
    checks++;
    if (o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag_set: out_ovf=%b, required 1", o);
    end
`endif
    send_elem(16'hFBFF, 1'b0);
    send_elem(16'hFBFF, 1'b1);
    recv_result(d, c, o);
    checks++;
    if (d !== 16'hFC00) begin
      errors++;
      $display("FAIL ovf_neg: out_data=%h, required fc00", d);
    end
    send_elem(one_val, 1'b1);
    recv_result(d, c, o);
    checks++;
    if (d !== 16'h3C00 || c !== 8'd1) begin
      errors++;
      $display("FAIL after_ovf: out_data=%h out_count=%0d, required 3c00 1", d, c);
    end
`ifdef FP_ACC_OVF_FLAG_EN
    checks++;
    if (o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flag_clear: out_ovf=%b, required 0", o);
    end
`endif
  endtask

  task automatic test_busy_timing();
    send_elem(16'h3C00, 1'b0);
    // acc=+0: align, add, one norm cycle, round
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_min[%0d]: in_ready=%b, required 0", i, bus.in_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_min_release: in_ready=%b, required 1", bus.in_ready);
    end
    send_elem(16'hBBFF, 1'b1);
    // 1.0 - 0.99951 cancels to 2^-11: 11 normalize shifts
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL busy_max[%0d]: in_ready=%b out_valid=%b, required 0 0", i, bus.in_ready, bus.out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== 16'h1000 || bus.out_count !== 8'd2) begin
      errors++;
      $display("FAIL busy_max_result: out_valid=%b in_ready=%b out_data=%h out_count=%0d, required 1 0 1000 2",
               bus.out_valid, bus.in_ready, bus.out_data, bus.out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int n = 0;
    bus.out_ready = 1'b0;
    send_elem(16'h3C00, 1'b0);
    send_elem(16'h3C00, 1'b1);
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== 16'h4000 || bus.out_count !== 8'd2) begin
        errors++;
        $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b out_data=%h out_count=%0d, required 1 0 4000 2",
                 i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_count);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] d;
    logic [7:0]  c;
    logic        o;
    for (int i = 0; i < 256; i++) begin
      send_elem(one_val, (i == 255) ? 1'b1 : 1'b0);
    end
    recv_result(d, c, o);
    checks++;
    if (d !== 16'h5C00 || c !== 8'hFF) begin
      errors++;
      $display("FAIL saturation: out_data=%h out_count=%0d, required 5c00 255", d, c);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d;
    logic [7:0]  c;
    logic        o;
    send_elem(16'h3C00, 1'b0);
    send_elem(16'hBBFF, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_state: in_ready=%b out_valid=%b out_data=%h out_count=%0d, required 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_count);
    end
    send_elem(16'h3C00, 1'b1);
    recv_result(d, c, o);
    checks++;
    if (d !== 16'h3C00 || c !== 8'd1) begin
      errors++;
      $display("FAIL mid_reset_frame: out_data=%h out_count=%0d, required 3c00 1", d, c);
    end
  endtask

  initial begin
    one_val       = {1'b0, 5'(EXP_BIAS), 10'h000};
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_busy_timing();
    test_special();
    test_arith();
    test_overflow();
    test_backpressure();
    test_saturation();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_stream_accumulator.md
Name: fp16_stream_accumulator

Overview:
- Downstream consumer of the half-precision float_add path.
- Sums a framed stream of FP16 values into one FP16 result using a multi-cycle datapath: align, add, normalize, round.
- Valid/ready handshake on both sides; one result per frame.
- Feeds the reduction/dot-product stages of the floating-point datapath.

Parameters:
- float_width, 16: total float width.
- exponent_width, 5: exponent field width; bias = 15.
- mantissa_width, 10: stored mantissa width; hidden bit is implicit.
- count_width, 8: width of the per-frame element counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  float_width  FP16 operand.
- in_last  in  1  marks the final element of a frame.
- out_valid  out  1  frame sum valid.
- out_ready  in  1  consumer accepts the sum.
- out_data  out  float_width  FP16 frame sum.
- out_count  out  count_width  elements in the frame; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a posedge):
  - State IDLE; accumulator = +0 (16'h0000); count = 0.
  - in_ready = 1, out_valid = 0, out_data = 0, out_count = 0.
  - Reset mid-operation discards everything in flight.
- States: IDLE, ALIGN, ADD, NORM, ROUND, OUT.
- IDLE:
  - in_ready = 1 only in IDLE.
  - On in_valid & in_ready: latch operand and in_last, increment count, go to ALIGN.
- ALIGN (1 cycle):
  - Unpack both operands to 11-bit significands plus guard/round/sticky bits.
  - Right-shift the smaller-exponent significand by the exponent difference; shifted-out bits OR into sticky.
  - Difference > 13: operand collapses to sticky only.
- ADD (1 cycle):
  - Same signs: add magnitudes.
  - Different signs: subtract the smaller magnitude from the larger; result takes the larger operand's sign.
- NORM (max(1,k) cycles):
  - Carry out: shift right 1, exponent+1, in 1 cycle.
  - Otherwise shift left 1 bit per cycle, decrementing the exponent, until the hidden bit = 1.
  - Exact zero: result +0, leave after 1 cycle.
  - Exponent reaching 0: flush to zero with sign preserved (FTZ).
- ROUND (1 cycle):
  - Round to nearest, ties to even.
  - Mantissa overflow from rounding: exponent+1.
  - Exponent >= 31: ±inf (16'h7C00 / 16'hFC00).
  - Write the accumulator.
  - If the latched last = 1 go to OUT, else IDLE.
- Busy time per element: 4..14 cycles with in_ready = 0.
- Special inputs:
  - Exponent 0 input is treated as zero (FTZ).
  - Any NaN input, or +inf and -inf together in the same frame: sum = 16'h7E00 (sticky for the frame).
  - A single infinity (no NaN, no opposite-signed infinity in the frame): sum = that infinity.
  - +0 plus -0 = +0.
- OUT:
  - out_valid = 1; out_data and out_count held stable until out_ready.
  - On handshake: accumulator = +0, count = 0, go to IDLE.
  - in_ready stays 0 while in OUT.
- A single-element frame yields that element (after FTZ).
- in_last without in_valid is ignored.

Optional Feature:
- Macro: FP_ACC_OVF_FLAG_EN.
- Defined:
  - Adds port out_ovf (out, 1).
  - out_ovf is a sticky per-frame flag set when any ROUND produces inf from finite operands.
  - Valid with out_valid; cleared on the OUT handshake and on reset.
- Undefined: port and logic absent; otherwise identical behaviour.

Decomposition:
- Package fp16_pkg holds:
  - width constants;
  - EXP_BIAS = 15, EXP_MAX = 31;
  - constants QNAN = 16'h7E00, POS_INF = 16'h7C00, NEG_INF = 16'hFC00;
  - the state enum typedef;
  - an unpacked-float struct typedef (sign, exponent, 14-bit extended significand).
- Sub-module fp16_rne_round: combinational.
  - Inputs: sign, exponent, extended significand.
  - Output: packed FP16 with RNE and overflow-to-inf applied.
  - Instantiated once, in ROUND.

Test Plan:
- Frame {16'h3C00, 16'h3C00(last)} -> out_data = 16'h4000, out_count = 2.
- Frame {16'h34CD, 16'h3266(last)} (0.3+0.2) -> out_data = 16'h3800.
- Frame {16'h34CD, 16'h34CD(last)} -> out_data = 16'h38CD.
- Frame {16'h3C00, 16'hBBFF(last)} -> out_data = 16'h1000; in_ready low for 14 cycles after the second accept.
- Frame {16'h3C00, 16'hBC00(last)} -> out_data = 16'h0000.
- Frame {16'h7BFF, 16'h7BFF(last)}:
  - out_data = 16'h7C00;
  - out_ovf = 1 with FP_ACC_OVF_FLAG_EN.
- Backpressure: out_ready low for 5 cycles -> out_data/out_count stable and in_ready = 0 throughout.
- Reset mid-frame: rst pulsed during NORM -> next frame {16'h3C00(last)} -> 16'h3C00, out_count = 1.
